// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Shift-add multiply, restoring divide, one bit per cycle.
`ifndef REG_FILE_WIDTH
`define REG_FILE_WIDTH 32
`endif

module mul_div_unit #(
  parameter int WIDTH = `REG_FILE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             abort,
  output logic             done,
  output logic [WIDTH-1:0] w,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_b;
  logic               r_sq;
  logic               r_sr;
  logic               r_dzop;
  logic               r_ready;
  logic               r_done;
  logic [WIDTH-1:0]   r_w;
  logic               r_dz;

  logic               w_sgn_in;
  logic               w_div_in;
  logic [WIDTH-1:0]   w_amag;
  logic [WIDTH-1:0]   w_bmag;
  logic               w_isdiv;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_mul_neg;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_res;

  // Signed ops work on magnitudes; sign is restored at the end.
  assign w_sgn_in = (op == 3'd1) || (op == 3'd3) || (op == 3'd5);
  assign w_div_in = (op >= 3'd3) && (op <= 3'd6);
  assign w_amag   = (w_sgn_in && x[WIDTH-1]) ? -x : x;
  assign w_bmag   = (w_sgn_in && y[WIDTH-1]) ? -y : y;
  assign w_isdiv  = (r_op >= 3'd3) && (r_op <= 3'd6);

  // Multiply step: add multiplicand into the high half, shift right.
  assign w_add      = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                    + (r_prod[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_add, r_prod[WIDTH-1:1]};
  assign w_mul_neg  = r_sq ? -w_mul_next : w_mul_next;

  // Divide step: shift in next dividend bit, try to subtract.
  assign w_rsh      = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_ge       = (w_rsh >= {1'b0, r_b});
  assign w_diff     = w_rsh - {1'b0, r_b};
  assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0]),
                       r_prod[WIDTH-2:0], w_ge};

  assign w_step = w_isdiv ? w_div_next : w_mul_next;
  assign w_q    = w_div_next[WIDTH-1:0];
  assign w_r    = w_div_next[2*WIDTH-1:WIDTH];

  // Final result select, using the value of the last iteration.
  always_comb begin
    w_res = '0;
    case (r_op)
      3'd0:       w_res = w_mul_next[WIDTH-1:0];
      3'd1:       w_res = w_mul_neg[2*WIDTH-1:WIDTH];
      3'd2:       w_res = w_mul_next[2*WIDTH-1:WIDTH];
      3'd3, 3'd4: w_res = r_dzop ? '1 : (r_sq ? -w_q : w_q);
      3'd5, 3'd6: w_res = r_sr ? -w_r : w_r;
      default:    w_res = '0;
    endcase
  end

  // Control FSM with iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_prod  <= '0;
      r_b     <= '0;
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
      r_dzop  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_w     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_in && r_ready && !abort) begin
            r_op    <= op;
            r_prod  <= {{WIDTH{1'b0}}, w_amag};
            r_b     <= w_bmag;
            r_sq    <= w_sgn_in && (x[WIDTH-1] ^ y[WIDTH-1]);
            r_sr    <= w_sgn_in && x[WIDTH-1];
            r_dzop  <= w_div_in && (y == '0);
            r_cnt   <= CNT_W'(WIDTH);
            r_ready <= 1'b0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (abort) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_prod <= w_step;
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_w     <= w_res;
              r_dz    <= r_dzop;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign done     = r_done && !abort;
  assign w        = r_w;
  assign div_zero = r_dz;

endmodule
